// File: rtl/bpred_update_queue.sv
// Ordered buffer of pending predictor-table writes with same-index merging,
// a read-path bypass for pending data, and a saturating drop counter.
module bpred_update_queue #(
    parameter int ENTRY_NUM           = 32,
    parameter int ADDR_WIDTH          = 32,
    parameter int INSN_ADDR_BIT_WIDTH = 2,
    parameter int INDEX_WIDTH         = 10,
    parameter int DATA_WIDTH          = 18,
    parameter int COALESCE            = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           pushValid,
    input  logic [ADDR_WIDTH-1:0]          pushAddr,
    input  logic [DATA_WIDTH-1:0]          pushData,
    input  logic                           tableBusy,
    output logic                           wrValid,
    output logic [INDEX_WIDTH-1:0]         wrIndex,
    output logic [DATA_WIDTH-1:0]          wrData,
    input  logic [INDEX_WIDTH-1:0]         lookupIndex,
    output logic                           lookupHit,
    output logic [DATA_WIDTH-1:0]          lookupData,
    output logic [$clog2(ENTRY_NUM):0]     count,
    output logic                           full,
    output logic                           empty,
    output logic [15:0]                    dropCount
);
    localparam int PTR_W  = $clog2(ENTRY_NUM);
    localparam int CNT_W  = PTR_W + 1;
    localparam int IDX_HI = INDEX_WIDTH + INSN_ADDR_BIT_WIDTH - 1;

    logic [PTR_W-1:0]       head, tail;
    logic [CNT_W-1:0]       count_q;
    logic [ENTRY_NUM-1:0]   ent_valid;
    logic [INDEX_WIDTH-1:0] ent_index [ENTRY_NUM];
    logic [DATA_WIDTH-1:0]  ent_data  [ENTRY_NUM];

    logic [INDEX_WIDTH-1:0] push_index;
    logic                   pop, coal_hit, coalesce, alloc, drop;
    logic [PTR_W-1:0]       coal_ptr;
    logic                   unused_addr;

    assign push_index  = pushAddr[IDX_HI:INSN_ADDR_BIT_WIDTH];
    assign unused_addr = ^{pushAddr[ADDR_WIDTH-1:IDX_HI+1], pushAddr[INSN_ADDR_BIT_WIDTH-1:0]};

    assign count   = count_q;
    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(ENTRY_NUM));
    assign pop     = !empty && !tableBusy;
    assign wrValid = pop;
    assign wrIndex = ent_index[head];
    assign wrData  = ent_data[head];

    // A head leaving this cycle cannot absorb a merge; the update must land behind it.
    always_comb begin
        coal_hit = 1'b0;
        coal_ptr = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (ent_valid[i] && ent_index[i] == push_index && !(pop && PTR_W'(i) == head)) begin
                coal_hit = 1'b1;
                coal_ptr = PTR_W'(i);
            end
        end
    end

    assign coalesce = (COALESCE != 0) && pushValid && coal_hit;
    assign alloc    = pushValid && !coalesce && (!full || pop);
    assign drop     = pushValid && !coalesce && full && !pop;

    // Walk oldest to youngest so the last match (nearest tail) wins.
    always_comb begin
        logic [PTR_W-1:0] p;
        lookupHit  = 1'b0;
        lookupData = '0;
        p          = head;
        for (int k = 0; k < ENTRY_NUM; k++) begin
            p = head + PTR_W'(k);
            if (ent_valid[p] && ent_index[p] == lookupIndex) begin
                lookupHit  = 1'b1;
                lookupData = ent_data[p];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count_q   <= '0;
            ent_valid <= '0;
            dropCount <= '0;
        end else begin
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + PTR_W'(1);
            end
            if (alloc) begin
                ent_valid[tail] <= 1'b1;
                tail            <= tail + PTR_W'(1);
            end
            if (alloc && !pop)
                count_q <= count_q + CNT_W'(1);
            else if (!alloc && pop)
                count_q <= count_q - CNT_W'(1);
            if (drop && dropCount != 16'hFFFF)
                dropCount <= dropCount + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) begin
            ent_index[tail] <= push_index;
            ent_data[tail]  <= pushData;
        end else if (coalesce) begin
            ent_data[coal_ptr] <= pushData;
        end
    end

endmodule
